// File: rtl/secuenciador_instrucciones.sv
// Instruction sequencer: loadable program memory, PC stepping,
// valid/ready emission of 20-bit words, stops on halt or end of memory.
module secuenciador_instrucciones #(
  parameter int          PROF = 32,
  parameter int          AW   = 5,
  parameter logic [19:0] HALT = 20'hFFFFF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          INICIO,
  input  logic          CARGA_WE,
  input  logic [AW-1:0] CARGA_DIR,
  input  logic [19:0]   CARGA_DATO,
  input  logic          LISTO,
  output logic [19:0]   INSTRUCCION,
  output logic          VALIDO,
  output logic [AW-1:0] PC,
  output logic          OCUPADO,
  output logic          FIN
);

  typedef enum logic [1:0] {
    S_REPOSO,
    S_LEER,
    S_EMITIR,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [19:0]   dato_q, dato_d;
  logic [19:0]   mem [PROF];

  logic es_halt;
  logic inactivo;
  logic mem_we;
  logic ultimo;

  assign es_halt  = (dato_q == HALT);
  assign inactivo = (state_q == S_REPOSO)
                 || (state_q == S_FIN);
  assign mem_we   = CARGA_WE && inactivo;
  assign ultimo   = (pc_q == AW'(PROF - 1));

  // Memory is deliberately not reset; only contents loaded by the host matter.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[CARGA_DIR] <= CARGA_DATO;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_REPOSO;
      pc_q    <= '0;
      dato_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dato_q  <= dato_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dato_d  = dato_q;
    unique case (state_q)
      S_REPOSO, S_FIN: begin
        if (INICIO) begin
          pc_d    = '0;
          state_d = S_LEER;
        end
      end
      S_LEER: begin
        dato_d  = mem[pc_q];
        state_d = S_EMITIR;
      end
      S_EMITIR: begin
        if (es_halt) begin
          state_d = S_FIN;
        end else if (LISTO) begin
          if (ultimo) begin
            state_d = S_FIN;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_LEER;
          end
        end
      end
    endcase
  end

  // Outputs come only from state and registers, never from LISTO.
  always_comb begin
    VALIDO      = (state_q == S_EMITIR) && !es_halt;
    INSTRUCCION = VALIDO ? dato_q : '0;
    PC          = pc_q;
    OCUPADO     = (state_q == S_LEER)
               || (state_q == S_EMITIR);
    FIN         = (state_q == S_FIN);
  end

endmodule
